// File: rtl/mega_mul_seq.sv
// Iterative 8x8 shift-add multiply sequencer (MUL/MULS/MULSU/FMUL/FMULS/FMULSU).
// Define MEGA_MUL_SEQ_SIGNED_EN to enable the signed/fractional ops; otherwise every op is unsigned MUL.
module mega_mul_seq #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        flag_c,
    output logic        flag_z
);

    localparam int          RUN_LEN  = 8 / ITER_BITS;
    localparam logic [2:0]  LAST_CNT = 3'(RUN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic        b_signed_q, b_signed_d;
    logic        frac_q, frac_d;
    logic [15:0] product_q, product_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;

    logic        a_signed_s;
    logic        b_signed_s;
    logic        frac_s;
    logic [15:0] term_s;
    logic [15:0] acc_step_s;
    logic [15:0] result_s;

`ifdef MEGA_MUL_SEQ_SIGNED_EN
    // Operand signedness and fractional shift decoded from the opcode.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        frac_s     = 1'b0;
        case (op)
            3'd1: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            3'd2: begin a_signed_s = 1'b1; end
            3'd3: begin frac_s = 1'b1; end
            3'd4: begin a_signed_s = 1'b1; b_signed_s = 1'b1; frac_s = 1'b1; end
            3'd5: begin a_signed_s = 1'b1; frac_s = 1'b1; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; frac_s = 1'b0; end
        endcase
    end
`else
    logic unused_op_s;
    assign unused_op_s = ^op;
    assign a_signed_s  = 1'b0;
    assign b_signed_s  = 1'b0;
    assign frac_s      = 1'b0;
`endif

    // Partial-product accumulation for the multiplier bits consumed this cycle.
    always_comb begin
        acc_step_s = acc_q;
        term_s     = 16'h0000;
        for (int j = 0; j < ITER_BITS; j++) begin
            term_s = mplier_q[j] ? (mcand_q << j) : 16'h0000;
            // A signed multiplier's MSB carries weight -2^7, so it is subtracted.
            if (b_signed_q && (cnt_q == LAST_CNT) && (j == ITER_BITS - 1)) begin
                acc_step_s = acc_step_s - term_s;
            end else begin
                acc_step_s = acc_step_s + term_s;
            end
        end
        result_s = frac_q ? {acc_step_s[14:0], 1'b0} : acc_step_s;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        b_signed_d = b_signed_q;
        frac_d     = frac_q;
        product_d  = product_q;
        flag_c_d   = flag_c_q;
        flag_z_d   = flag_z_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d    = ST_RUN;
                    cnt_d      = 3'd0;
                    acc_d      = 16'h0000;
                    mcand_d    = a_signed_s ? {{8{a[7]}}, a} : {8'h00, a};
                    mplier_d   = b;
                    b_signed_d = b_signed_s;
                    frac_d     = frac_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step_s;
                    mcand_d  = mcand_q << ITER_BITS;
                    mplier_d = mplier_q >> ITER_BITS;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d   = ST_DONE;
                        product_d = result_s;
                        flag_c_d  = acc_step_s[15];
                        flag_z_d  = (result_s == 16'h0000);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            mcand_q    <= 16'h0000;
            mplier_q   <= 8'h00;
            acc_q      <= 16'h0000;
            b_signed_q <= 1'b0;
            frac_q     <= 1'b0;
            product_q  <= 16'h0000;
            flag_c_q   <= 1'b0;
            flag_z_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            b_signed_q <= b_signed_d;
            frac_q     <= frac_d;
            product_q  <= product_d;
            flag_c_q   <= flag_c_d;
            flag_z_q   <= flag_z_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE) && !flush;
    assign product = product_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;

endmodule

// File: doc/mega_mul_seq.md
Name: mega_mul_seq

Overview:
- Iterative 8x8 multiply sequencer for core variants built without the single-cycle hardware multiplier (CLASSIC_8K / CLASSIC_128K class).
- Executes MUL-family instructions over multiple cycles on its own shift-add datapath, with a start/busy/done handshake to the core control.
- Returns the 16-bit product plus C and Z flags; the core writes the product to R1:R0.
- Sits beside the ALU, and the core stalls its pipeline while busy is high.

Parameters:
- ITER_BITS, 1, multiplier bits consumed per RUN cycle. Legal values 1, 2, 4. RUN length is 8/ITER_BITS cycles.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active low.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  3  operation: 0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU. 6 and 7 are reserved and execute as MUL.
- a  in  8  multiplicand (Rd). Latched on accepted start.
- b  in  8  multiplier (Rr). Latched on accepted start.
- flush  in  1  abort the current operation, e.g. on pipeline flush.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- product  out  16  result.
- flag_c  out  1  carry flag result.
- flag_z  out  1  zero flag result.

Behaviour:
- Clocking and reset:
  - One clock. rst is synchronous, active low.
  - When rst=0 at an edge: state=IDLE; busy, done, flag_c, flag_z = 0; product = 0x0000; internal accumulator and counter cleared.
  - Reset mid-operation abandons the operation with no done.
- State machine:
  - IDLE: start=1 and flush=0 at an edge -> latch a, b, op; clear the accumulator; counter=0; go to RUN. start=0 -> stay in IDLE.
  - RUN: each edge consumes ITER_BITS multiplier bits, LSB first, and increments the counter. When counter reaches 8/ITER_BITS-1, go to DONE.
  - DONE: product, flag_c and flag_z update at the edge entering DONE; done=1 for exactly this cycle. Next edge -> IDLE.
- Latency (ITER_BITS=1), with start sampled at end of cycle 0:
  - busy=1 in cycles 1..9; done=1 in cycle 9; busy=0 from cycle 10.
  - A new start is accepted in cycle 10. Back-to-back throughput is one operation per 10 cycles.
- busy is combinationally equal to (state != IDLE).
- start while busy is ignored. No queuing, no error.
- Operand changes on a, b or op after acceptance have no effect.
- flush:
  - In RUN or DONE, returns to IDLE at the next edge and suppresses done for that cycle.
  - product and flags keep their previous values.
  - flush=1 together with start=1 in IDLE: flush wins and nothing is accepted.
- Arithmetic:
  - a is treated as signed for MULS, MULSU, FMULS and FMULSU.
  - b is treated as signed for MULS and FMULS only.
  - The raw 16-bit product P is the exact two's-complement or unsigned product, computed as shift-add with a sign-extended multiplicand. For a signed multiplier, the final step subtracts instead of adds.
  - flag_c = P[15] for all ops. For the FMUL variants this is the bit shifted out.
  - product = P for MUL/MULS/MULSU; product = P<<1 (LSB 0) for FMUL/FMULS/FMULSU.
  - flag_z = (product == 0), evaluated after the shift.
- Outputs product, flag_c and flag_z hold between done pulses.

Optional Feature:
- Macro: MEGA_MUL_SEQ_SIGNED_EN.
- Defined: all six ops as above.
- Undefined: signed and fractional datapath logic is removed. Every op value executes as unsigned MUL (no shift, flag_c = P[15]). Timing and handshake are unchanged.

Test Plan:
- MUL a=0xFF b=0xFF, ITER_BITS=1 -> done in cycle 9 only; product=0xFE01, flag_c=1, flag_z=0; busy cycles 1..9.
- MULSU a=0xFF b=0x02 -> product=0xFFFE, flag_c=1. MULS a=0x80 b=0x80 -> product=0x4000, flag_c=0, flag_z=0.
- FMUL a=0x80 b=0x80 -> product=0x8000, flag_c=0. FMULS a=0x80 b=0x80 -> product=0x8000, flag_c=0. MUL a=0x00 b=0x5A -> product=0x0000, flag_z=1.
- During the MUL 0x03*0x04 run, assert start with a=0xFF b=0xFF in cycle 3 and change a/b every cycle -> single done with product=0x000C; the second start is ignored.
- Complete MUL 0x03*0x04 (product=0x000C), start MUL 0x10*0x10, assert flush in cycle 4 -> busy=0 from cycle 5, no done, product stays 0x000C. Repeat with rst=0 in cycle 4 -> all outputs 0 next cycle, no done.
- MEGA_MUL_SEQ_SIGNED_EN undefined, op=2 a=0xFF b=0x02 -> product=0x01FE, flag_c=0. Repeat with ITER_BITS=2 and 4 -> done in cycle 5 and cycle 3 respectively, same result.
